// File: rtl/cpu_bus_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_bus_decoder_if
//  Purpose  : CPU-side request/acknowledge bus between the CPU and the
//             region decoder. Macro DEC_ERR_CAPTURE_EN adds the fault-capture
//             signals.
//  Revision : 1.0 - initial release
// ============================================================================
interface cpu_bus_decoder_if #(
    parameter int ADDR_W  = 13,
    parameter int NUM_REG = 3
);
    logic                req;
    logic [ADDR_W-1:0]   addr;
    logic [NUM_REG-1:0]  sel;
    logic                ack;
    logic                err;
    logic                busy;
`ifdef DEC_ERR_CAPTURE_EN
    logic                err_clr;
    logic [ADDR_W-1:0]   err_addr;
    logic                err_valid;

    modport master (
        output req, addr, err_clr,
        input  sel, ack, err, busy, err_addr, err_valid
    );
    modport slave (
        input  req, addr, err_clr,
        output sel, ack, err, busy, err_addr, err_valid
    );
`else
    modport master (
        output req, addr,
        input  sel, ack, err, busy
    );
    modport slave (
        input  req, addr,
        output sel, ack, err, busy
    );
`endif
endinterface
`default_nettype wire

// File: rtl/cpu_bus_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_bus_decoder
//  Purpose  : Registered base/mask address decoder with per-region wait
//             states, ack/err handshake. Macro DEC_ERR_CAPTURE_EN adds
//             first-fault address capture.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_bus_decoder #(
    parameter int                          ADDR_W   = 13,
    parameter int                          NUM_REG  = 3,
    parameter logic [NUM_REG*ADDR_W-1:0]   REG_BASE = {13'h1800, 13'h1000, 13'h0000},
    parameter logic [NUM_REG*ADDR_W-1:0]   REG_MASK = {13'h1800, 13'h1800, 13'h1000},
    parameter logic [NUM_REG*4-1:0]        REG_WAIT = {4'd0, 4'd1, 4'd1}
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    cpu_bus_decoder_if.slave   bus
);

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_WAIT = 2'd1;
    localparam logic [1:0] C_ST_ACK  = 2'd2;
    localparam logic [1:0] C_ST_ERR  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = C_ST_IDLE,
        ST_WAIT = C_ST_WAIT,
        ST_ACK  = C_ST_ACK,
        ST_ERR  = C_ST_ERR
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;
    logic [NUM_REG-1:0]  r_sel;
    logic [NUM_REG-1:0]  w_sel_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_nxt;

    logic [ADDR_W-1:0]   w_dec_addr;
    logic [NUM_REG-1:0]  w_hit;
    logic [NUM_REG-1:0]  w_onehot;
    logic [3:0]          w_wait;
    logic                w_any_hit;

    // One decoder serves both the live bus address (IDLE) and the latched
    // address (WAIT), so the hit/miss decision in WAIT ignores later addr changes.
    assign w_dec_addr = (r_state == ST_IDLE) ? bus.addr : r_addr;

    for (genvar gi = 0; gi < NUM_REG; gi++) begin : g_hit
        assign w_hit[gi] = ((w_dec_addr & REG_MASK[gi*ADDR_W +: ADDR_W])
                            == REG_BASE[gi*ADDR_W +: ADDR_W]);
    end

    always_comb begin
        w_onehot  = '0;
        w_wait    = 4'd0;
        w_any_hit = 1'b0;
        // Walk from the top down so the lowest matching index is left standing.
        for (int i = NUM_REG - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_onehot    = '0;
                w_onehot[i] = 1'b1;
                w_wait      = REG_WAIT[i*4 +: 4];
                w_any_hit   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_sel   <= '0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
            r_addr  <= w_addr_nxt;
        end
    end

    // WAIT is always entered after a sample; it doubles as the decode cycle,
    // giving W+1 WAIT cycles for a hit and a single one before ERR on a miss.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_addr_nxt  = r_addr;
        case (r_state)
            ST_IDLE: begin
                if (bus.req) begin
                    w_addr_nxt  = bus.addr;
                    w_sel_nxt   = w_onehot;
                    w_cnt_nxt   = w_any_hit ? w_wait : 4'd0;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = w_any_hit ? ST_ACK : ST_ERR;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_ACK: begin
                w_sel_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                w_sel_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_sel_nxt   = '0;
                w_cnt_nxt   = 4'd0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.sel  = r_sel;
    assign bus.ack  = (r_state == ST_ACK);
    assign bus.err  = (r_state == ST_ERR);
    assign bus.busy = (r_state != ST_IDLE);

`ifdef DEC_ERR_CAPTURE_EN
    logic [ADDR_W-1:0] r_err_addr;
    logic              r_err_valid;
    logic              w_err_entry;

    assign w_err_entry = (w_state_nxt == ST_ERR) && (r_state != ST_ERR);

    // A clear on the same edge as a new fault wins; the fault is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_addr  <= '0;
            r_err_valid <= 1'b0;
        end else if (bus.err_clr) begin
            r_err_valid <= 1'b0;
        end else if (w_err_entry && !r_err_valid) begin
            r_err_addr  <= r_addr;
            r_err_valid <= 1'b1;
        end
    end

    assign bus.err_addr  = r_err_addr;
    assign bus.err_valid = r_err_valid;
`endif

endmodule
`default_nettype wire
